// File: rtl/classifier_pkg.sv
// Shared types and default sizing for the classifier feeder: FSM state enum,
// int4/int8 data types and default feature/class counts.
package classifier_pkg;

    localparam int unsigned N_FEAT_DEF     = 16;
    localparam int unsigned N_CLASS_DEF    = 8;
    localparam int unsigned CLASS_BITS_DEF = 3;
    localparam int unsigned FEAT_BITS_DEF  = 4;

    typedef logic signed [3:0] int4_t;
    typedef logic signed [7:0] int8_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StClose,
        StFinish
    } state_e;

endpackage

// File: rtl/classifier_idx_counter.sv
// Nested feature/class index counter: f wraps at N_FEAT-1, c saturates at
// N_CLASS-1 and only returns to 0 through an explicit clear.
module classifier_idx_counter #(
    parameter int unsigned N_FEAT     = 16,
    parameter int unsigned N_CLASS    = 8,
    parameter int unsigned FEAT_BITS  = 4,
    parameter int unsigned CLASS_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  inc_f_i,
    input  logic                  inc_c_i,
    output logic [FEAT_BITS-1:0]  f_o,
    output logic [CLASS_BITS-1:0] c_o,
    output logic                  f_last_o,
    output logic                  c_last_o
);

    logic [FEAT_BITS-1:0]  f_q, f_d;
    logic [CLASS_BITS-1:0] c_q, c_d;

    assign f_last_o = (f_q == FEAT_BITS'(N_FEAT - 1));
    assign c_last_o = (c_q == CLASS_BITS'(N_CLASS - 1));
    assign f_o      = f_q;
    assign c_o      = c_q;

    always_comb begin
        f_d = f_q;
        c_d = c_q;
        if (clr_i) begin
            f_d = '0;
            c_d = '0;
        end else begin
            if (inc_f_i) begin
                f_d = f_last_o ? '0 : f_q + FEAT_BITS'(1);
            end
            if (inc_c_i && !c_last_o) begin
                c_d = c_q + CLASS_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q <= '0;
            c_q <= '0;
        end else begin
            f_q <= f_d;
            c_q <= c_d;
        end
    end

endmodule

// File: rtl/classifier_feeder.sv
// Streams activation/weight pairs class by class into a downstream MAC/argmax.
// Optional zero-skipping of new_feat is enabled by CLASSIFIER_FEEDER_ZSKIP_EN.
module classifier_feeder
    import classifier_pkg::*;
#(
    parameter int unsigned N_FEAT     = N_FEAT_DEF,
    parameter int unsigned N_CLASS    = N_CLASS_DEF,
    parameter int unsigned CLASS_BITS = CLASS_BITS_DEF,
    parameter int unsigned FEAT_BITS  = FEAT_BITS_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            act_rd_en,
    output logic [FEAT_BITS-1:0]            act_addr,
    input  int4_t                           act_data,
    output logic                            w_rd_en,
    output logic [CLASS_BITS+FEAT_BITS-1:0] w_addr,
    input  int8_t                           w_data,
    output int4_t                           x_int4,
    output int8_t                           w_int8,
    output logic                            new_feat,
    output logic                            new_class,
    output logic [CLASS_BITS-1:0]           class_id,
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned AW = CLASS_BITS + FEAT_BITS;

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  feat_q, feat_d;
    logic                  new_class_q, new_class_d;
    logic [CLASS_BITS-1:0] class_id_q, class_id_d;
    logic [AW-1:0]         w_addr_q, w_addr_d;

    logic [FEAT_BITS-1:0]  f_cnt;
    logic [CLASS_BITS-1:0] c_cnt;
    logic                  f_last, c_last;

    classifier_idx_counter #(
        .N_FEAT     (N_FEAT),
        .N_CLASS    (N_CLASS),
        .FEAT_BITS  (FEAT_BITS),
        .CLASS_BITS (CLASS_BITS)
    ) u_idx (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q == StFinish),
        .inc_f_i  (state_q == StRun),
        .inc_c_i  (state_q == StClose),
        .f_o      (f_cnt),
        .c_o      (c_cnt),
        .f_last_o (f_last),
        .c_last_o (c_last)
    );

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        new_class_d = 1'b0;
        class_id_d  = class_id_q;
        w_addr_d    = w_addr_q;
        feat_d      = (state_q == StRun);
        case (state_q)
            StIdle: begin
                // The done cycle is spent in IDLE; start is not taken there.
                if (start && !done_q) begin
                    state_d = StRun;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                w_addr_d = w_addr_q + AW'(1);
                if (f_last) begin
                    state_d = StClose;
                end
            end
            StClose: begin
                new_class_d = 1'b1;
                class_id_d  = c_cnt;
                state_d     = c_last ? StFinish : StRun;
            end
            StFinish: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                w_addr_d = '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            feat_q      <= 1'b0;
            new_class_q <= 1'b0;
            class_id_q  <= '0;
            w_addr_q    <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            feat_q      <= feat_d;
            new_class_q <= new_class_d;
            class_id_q  <= class_id_d;
            w_addr_q    <= w_addr_d;
        end
    end

    assign act_rd_en = (state_q == StRun);
    assign w_rd_en   = (state_q == StRun);
    assign act_addr  = f_cnt;
    assign w_addr    = w_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign new_class = new_class_q;
    assign class_id  = class_id_q;

    // Data is only presented while a read result is on the bus.
    assign x_int4 = feat_q ? act_data : '0;
    assign w_int8 = feat_q ? w_data : '0;

`ifdef CLASSIFIER_FEEDER_ZSKIP_EN
    assign new_feat = feat_q && (act_data != '0);
`else
    assign new_feat = feat_q;
`endif

endmodule

// File: tb/tb_classifier_feeder.sv
// Self-checking bench: schedule-based reference model checked every cycle,
// directed timing/reset/start-filter scenarios, random data and a sign test.
module tb_classifier_feeder;
    import classifier_pkg::*;

    localparam int NF = 4;
    localparam int NC = 3;
    localparam int P  = NF + 1;
    localparam int L  = NC * P;
    localparam int D  = L + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start16 = 1'b0;
    always #5 clk = ~clk;

    logic         act_rd_en, w_rd_en, new_feat, new_class, busy, done;
    logic [1:0]   act_addr, class_id;
    logic [3:0]   w_addr;
    int4_t        act_data, x_int4;
    int8_t        w_data, w_int8;

    logic         act_rd_en16, w_rd_en16, new_feat16, new_class16, busy16, done16;
    logic [3:0]   act_addr16;
    logic [0:0]   class_id16;
    logic [4:0]   w_addr16;
    int4_t        act_data16, x_int4_16;
    int8_t        w_data16, w_int8_16;

    classifier_feeder #(.N_FEAT(NF), .N_CLASS(NC), .CLASS_BITS(2), .FEAT_BITS(2)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .act_rd_en(act_rd_en), .act_addr(act_addr), .act_data(act_data),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
        .x_int4(x_int4), .w_int8(w_int8), .new_feat(new_feat), .new_class(new_class),
        .class_id(class_id), .busy(busy), .done(done)
    );

    classifier_feeder #(.N_FEAT(16), .N_CLASS(2), .CLASS_BITS(1), .FEAT_BITS(4)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16),
        .act_rd_en(act_rd_en16), .act_addr(act_addr16), .act_data(act_data16),
        .w_rd_en(w_rd_en16), .w_addr(w_addr16), .w_data(w_data16),
        .x_int4(x_int4_16), .w_int8(w_int8_16), .new_feat(new_feat16),
        .new_class(new_class16), .class_id(class_id16), .busy(busy16), .done(done16)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memories: one-cycle read latency, garbage when not read.
    logic signed [3:0] xm [NF];
    logic signed [7:0] wm [NC*NF];
    always @(posedge clk) begin
        act_data   <= act_rd_en ? xm[act_addr] : 4'($urandom);
        w_data     <= w_rd_en ? wm[w_addr] : 8'($urandom);
        act_data16 <= act_rd_en16 ? -4'sd8 : 4'($urandom);
        w_data16   <= w_rd_en16 ? ((w_addr16 >= 5'd16) ? -8'sd128 : 8'sd1) : 8'($urandom);
    end

    // Reference model: t counts cycles since start was sampled (-1 when idle).
    function automatic bit rd_at(input int tt);
        return tt >= 1 && tt <= L && ((tt - 1) % P) < NF;
    endfunction

    int t = -1;
    int m_fp, m_cp;
    bit m_rd, m_rdp, m_nf, m_nc;
    always @(negedge clk) begin
        if (rst) begin
            t = -1;
            chk("rst_act_rd_en", act_rd_en, 0);
            chk("rst_w_rd_en", w_rd_en, 0);
            chk("rst_act_addr", act_addr, 0);
            chk("rst_w_addr", w_addr, 0);
            chk("rst_new_feat", new_feat, 0);
            chk("rst_new_class", new_class, 0);
            chk("rst_class_id", class_id, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_x_int4", x_int4, 0);
            chk("rst_w_int8", w_int8, 0);
            chk("rst_busy16", busy16, 0);
            chk("rst_act_addr16", act_addr16, 0);
        end else begin
            m_rd  = rd_at(t);
            m_rdp = rd_at(t - 1);
            chk("act_rd_en", act_rd_en, m_rd);
            chk("w_rd_en", w_rd_en, m_rd);
            if (m_rd) begin
                chk("act_addr", act_addr, (t - 1) % P);
                chk("w_addr", w_addr, ((t - 1) / P) * NF + (t - 1) % P);
            end
            m_nf = 1'b0;
            if (m_rdp) begin
                m_fp = (t - 2) % P;
                m_cp = (t - 2) / P;
                chk("x_int4", x_int4, xm[m_fp]);
                chk("w_int8", w_int8, wm[m_cp * NF + m_fp]);
`ifdef CLASSIFIER_FEEDER_ZSKIP_EN
                m_nf = (xm[m_fp] != 0);
`else
                m_nf = 1'b1;
`endif
            end
            chk("new_feat", new_feat, m_nf);
            m_nc = t >= 2 && t <= L + 1 && ((t - 1) % P) == 0;
            chk("new_class", new_class, m_nc);
            if (m_nc) chk("class_id", class_id, (t - 1) / P - 1);
            chk("done", done, t == D);
            chk("busy", busy, t >= 1 && t <= L + 1);
            if (start && (t < 1 || t > D)) t = 1;
            else if (t >= 1 && t <= D) t = t + 1;
            else t = -1;
        end
    end

    // Monitor with downstream MAC/argmax.
    int nc_cyc[$];
    int done_cyc[$];
    int aa[$];
    int wa[$];
    int nf_cnt = 0;
    int mac_done = 0;
    longint acc = 0, mx = 0, last_score = 0;
    int mc = 0, last_class = 0;
    bit have = 1'b0;
    int done16_cyc = -1;
    longint acc16 = 0, mx16 = 0, last16_score = 0;
    int mc16 = 0, last16_class = -1;
    bit have16 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            acc = 0; have = 1'b0; acc16 = 0; have16 = 1'b0;
        end else begin
            if (act_rd_en) begin
                aa.push_back(int'(act_addr));
                wa.push_back(int'(w_addr));
            end
            if (new_feat) begin
                nf_cnt++;
                acc += longint'(x_int4) * longint'(w_int8);
            end
            if (new_class) begin
                nc_cyc.push_back(cyc);
                if (!have || acc > mx) begin mx = acc; mc = int'(class_id); have = 1'b1; end
                acc = 0;
            end
            if (done) begin
                done_cyc.push_back(cyc);
                last_score = mx; last_class = mc; mac_done++; have = 1'b0;
            end
            if (new_feat16) acc16 += longint'(x_int4_16) * longint'(w_int8_16);
            if (new_class16) begin
                if (!have16 || acc16 > mx16) begin
                    mx16 = acc16; mc16 = int'(class_id16); have16 = 1'b1;
                end
                acc16 = 0;
            end
            if (done16) begin
                done16_cyc = cyc; last16_score = mx16; last16_class = mc16; have16 = 1'b0;
            end
        end
    end

    task automatic run_inf(input bit noisy, output int s);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        s = cyc;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            start = noisy ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_seen", seen, 1);
    endtask

    int s, nc_b, dn_b, nf_b, a_b, md_b;
    int exp_nc[3];
    longint sc, best;
    int bestc;

    initial begin
        exp_nc = '{6, 11, 16};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed: x=1, w[c][f]=c+1, ignored starts at S+5 and done, restart at done+1.
        for (int f = 0; f < NF; f++) xm[f] = 4'sd1;
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++) wm[c*NF+f] = 8'(c + 1);
        @(posedge clk); #1;
        nc_b = nc_cyc.size(); dn_b = done_cyc.size(); nf_b = nf_cnt; a_b = aa.size();
        start = 1'b1;
        s = cyc;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk); #1;
            start = (k == 5 || k == 17 || k == 18);
            if (k == 18) begin
                chk("nc_count", nc_cyc.size() - nc_b, 3);
                for (int i = 0; i < 3; i++)
                    if (nc_b + i < nc_cyc.size()) chk("nc_cycle", nc_cyc[nc_b+i] - s, exp_nc[i]);
                chk("done_count", done_cyc.size() - dn_b, 1);
                if (dn_b < done_cyc.size()) chk("done_cycle", done_cyc[dn_b] - s, 17);
                chk("new_feat_count", nf_cnt - nf_b, 12);
                chk("addr_count", aa.size() - a_b, 12);
                for (int i = 0; i < 12; i++)
                    if (a_b + i < aa.size()) begin
                        chk("act_addr_seq", aa[a_b+i], i % 4);
                        chk("w_addr_seq", wa[a_b+i], i);
                    end
                chk("max_class", last_class, 2);
                chk("max_score", last_score, 12);
                chk("no_read_at_restart", act_rd_en, 0);
            end
            if (k == 19) begin
                chk("restart_rd_en", act_rd_en, 1);
                chk("restart_addr", act_addr, 0);
            end
        end

        // Reset at S2+8 (S2 = S+18) aborts the second inference.
        repeat (7) @(posedge clk);
        #1;
        chk("pre_reset_busy", busy, 1);
        rst = 1'b1;
        nc_b = nc_cyc.size(); dn_b = done_cyc.size();
        #1 chk("reset_busy_now", busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("no_class_after_rst", nc_cyc.size() - nc_b, 0);
        chk("no_done_after_rst", done_cyc.size() - dn_b, 0);

        // Zero activation at f=1: skipped pulses only when the feature is built in.
        xm[1] = 4'sd0;
        nc_b = nc_cyc.size(); dn_b = done_cyc.size(); nf_b = nf_cnt;
        run_inf(1'b0, s);
`ifdef CLASSIFIER_FEEDER_ZSKIP_EN
        chk("zs_new_feat_count", nf_cnt - nf_b, 9);
`else
        chk("zs_new_feat_count", nf_cnt - nf_b, 12);
`endif
        chk("zs_nc_count", nc_cyc.size() - nc_b, 3);
        for (int i = 0; i < 3; i++)
            if (nc_b + i < nc_cyc.size()) chk("zs_nc_cycle", nc_cyc[nc_b+i] - s, exp_nc[i]);
        if (dn_b < done_cyc.size()) chk("zs_done_cycle", done_cyc[dn_b] - s, 17);
        chk("zs_max_class", last_class, 2);
        chk("zs_max_score", last_score, 9);

        // Random data with random start noise while busy.
        for (int it = 0; it < 6; it++) begin
            for (int f = 0; f < NF; f++) xm[f] = 4'($urandom);
            for (int i = 0; i < NC*NF; i++) wm[i] = 8'($urandom);
            best = 0; bestc = 0;
            for (int c = 0; c < NC; c++) begin
                sc = 0;
                for (int f = 0; f < NF; f++) sc += longint'(xm[f]) * longint'(wm[c*NF+f]);
                if (c == 0 || sc > best) begin best = sc; bestc = c; end
            end
            md_b = mac_done; dn_b = done_cyc.size();
            run_inf(1'b1, s);
            chk("rnd_mac_done", mac_done - md_b, 1);
            if (dn_b < done_cyc.size()) chk("rnd_done_cycle", done_cyc[dn_b] - s, D);
            chk("rnd_max_class", last_class, bestc);
            chk("rnd_max_score", last_score, best);
        end

        // Sign pass-through: x=-8, w=-128 over 16 features gives +16384.
        @(posedge clk); #1;
        start16 = 1'b1;
        s = cyc;
        @(posedge clk); #1 start16 = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done16) break;
        end
        @(posedge clk); #1;
        chk("s16_done_cycle", done16_cyc - s, 2 * 17 + 2);
        chk("s16_max_class", last16_class, 1);
        chk("s16_max_score", last16_score, 16384);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
